// File: rtl/sine_meas_pkg.sv
// Shared types and default parameters for the sine period meter.
// Holds the measurement FSM state encoding and the default threshold and width constants.
package sine_meas_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int PERIOD_W_DEF = 16;
  localparam int MID_DEF      = 128;
  localparam int HYST_DEF     = 4;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } meas_state_e;

endpackage

// File: rtl/sine_xing_det.sv
// Rising midscale crossing detector with hysteresis.
// The detector arms below MID-HYST and fires on the first accepted sample at or above MID+HYST.
module sine_xing_det
  import sine_meas_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int MID      = MID_DEF,
  parameter int HYST     = HYST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_ena,
  input  logic                i_accept,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_xing
);

  localparam logic [SAMPLE_W-1:0] LO_TH = SAMPLE_W'(MID - HYST);
  localparam logic [SAMPLE_W-1:0] HI_TH = SAMPLE_W'(MID + HYST);

  logic r_armed;

  // The crossing is combinational so the top can act on it in the same cycle as the sample.
  assign o_xing = i_accept & r_armed & (i_sample >= HI_TH);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (!i_ena) begin
      r_armed <= 1'b0;
    end else if (o_xing) begin
      r_armed <= 1'b0;
    end else if (i_accept && (i_sample <= LO_TH)) begin
      r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/sine_period_meter.sv
// Measures period (in accepted samples) and peak max/min per cycle of a sampled sine.
// The window opens on a rising crossing sample and closes on the next one, which reseeds it.
module sine_period_meter
  import sine_meas_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int MID      = MID_DEF,
  parameter int HYST     = HYST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                meas_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [SAMPLE_W-1:0] peak_max,
  output logic [SAMPLE_W-1:0] peak_min,
  output logic                locked,
  output logic                timeout
);

  logic                w_accept;
  logic                w_xing;
  meas_state_e         r_state;
  meas_state_e         w_state_nxt;
  logic                w_seed;
  logic                w_count;
  logic                w_latch;
  logic                w_to_set;

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic [SAMPLE_W-1:0] r_run_max;
  logic [SAMPLE_W-1:0] r_run_min;
  logic [SAMPLE_W-1:0] r_peak_max;
  logic [SAMPLE_W-1:0] r_peak_min;
  logic                r_meas_valid;
  logic                r_locked;
  logic                r_timeout;
  logic                r_ena_d;

  assign w_accept = ena & sample_valid;

  sine_xing_det #(
    .SAMPLE_W(SAMPLE_W),
    .MID     (MID),
    .HYST    (HYST)
  ) u_xing (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_ena   (ena),
    .i_accept(w_accept),
    .i_sample(sample),
    .o_xing  (w_xing)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_FIRST;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_seed      = 1'b0;
    w_count     = 1'b0;
    w_latch     = 1'b0;
    w_to_set    = 1'b0;
    if (!ena) begin
      w_state_nxt = WAIT_FIRST;
    end else if (w_accept) begin
      unique case (r_state)
        WAIT_FIRST: begin
          if (w_xing) begin
            w_seed      = 1'b1;
            w_state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          if (w_xing) begin
            w_latch = 1'b1;
            w_seed  = 1'b1;
          end else if (r_cnt == '1) begin
            w_to_set    = 1'b1;
            w_state_nxt = WAIT_FIRST;
          end else begin
            w_count = 1'b1;
          end
        end
        default: w_state_nxt = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_run_max <= '0;
      r_run_min <= '1;
    end else if (w_seed) begin
      r_cnt     <= '0;
      r_run_max <= sample;
      r_run_min <= sample;
    end else if (w_count) begin
      r_cnt <= r_cnt + PERIOD_W'(1);
      if (sample > r_run_max) r_run_max <= sample;
      if (sample < r_run_min) r_run_min <= sample;
    end
  end

  // Measurement outputs hold their last value through timeout and ena-low periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period     <= '0;
      r_peak_max   <= '0;
      r_peak_min   <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_ena_d      <= 1'b0;
    end else begin
      r_ena_d      <= ena;
      r_meas_valid <= w_latch;
      if (w_latch) begin
        r_period   <= r_cnt + PERIOD_W'(1);
        r_peak_max <= r_run_max;
        r_peak_min <= r_run_min;
        r_locked   <= 1'b1;
      end
      if (w_to_set) begin
        r_timeout <= 1'b1;
        r_locked  <= 1'b0;
      end else if (ena && !r_ena_d) begin
        r_timeout <= 1'b0;
      end
      if (!ena) r_locked <= 1'b0;
    end
  end

  assign meas_valid = r_meas_valid;
  assign period     = r_period;
  assign peak_max   = r_peak_max;
  assign peak_min   = r_peak_min;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_sine_period_meter.sv
// Directed self-checking bench for sine_period_meter: a default-width instance and a
// PERIOD_W=4 instance (own enable) used for the counter-saturation scenario.
module tb_sine_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        ena2 = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample = 8'h00;

  logic        meas_valid, locked, timeout;
  logic [15:0] period;
  logic [7:0]  peak_max, peak_min;
  logic        meas_valid2, locked2, timeout2;
  logic [3:0]  period2;
  logic [7:0]  peak_max2, peak_min2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cyc[$];
  int pulses2 = 0;

  // One cycle of a sine starting at its minimum; the rising crossing is at index 5 (0xB0).
  logic [7:0] sine_tab [16] = '{8'h01, 8'h0B, 8'h26, 8'h50, 8'h80, 8'hB0, 8'hDA, 8'hF5,
                                8'hFF, 8'hF5, 8'hDA, 8'hB0, 8'h80, 8'h50, 8'h26, 8'h0B};

  sine_period_meter u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid), .sample(sample),
    .meas_valid(meas_valid), .period(period), .peak_max(peak_max), .peak_min(peak_min),
    .locked(locked), .timeout(timeout)
  );

  sine_period_meter #(.PERIOD_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .sample_valid(sample_valid), .sample(sample),
    .meas_valid(meas_valid2), .period(period2), .peak_max(peak_max2), .peak_min(peak_min2),
    .locked(locked2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (meas_valid) pulse_cyc.push_back(cyc);
    if (meas_valid2) pulses2++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic [7:0] s);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic gap();
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_samples(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      step(sine_tab[i % 16]);
      if (toggle) gap();
    end
  endtask

  task automatic do_reset(input logic e1, input logic e2);
    rst_n = 1'b0;
    ena = e1;
    ena2 = e2;
    sample_valid = 1'b0;
    sample = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b0);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_meas_valid: got %0b want 0", meas_valid); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
    checks++; if ({peak_max, peak_min} !== 16'h0000) begin errors++; $display("FAIL reset_peaks: got %h/%h want 00/00", peak_max, peak_min); end
    checks++; if ({locked, timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags: got locked=%0b timeout=%0b want 0/0", locked, timeout); end
  endtask

  task automatic test_idle();
    int base;
    base = pulse_cyc.size();
    for (int i = 0; i < 100; i++) step(8'd128);
    gap();
    checks++; if (pulse_cyc.size() !== base) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulse_cyc.size() - base); end
    checks++; if ({locked, timeout} !== 2'b00) begin errors++; $display("FAIL idle_flags: got locked=%0b timeout=%0b want 0/0", locked, timeout); end
  endtask

  task automatic test_sine_continuous();
    int base, c0;
    do_reset(1'b1, 1'b0);
    base = pulse_cyc.size();
    c0 = cyc;
    run_samples(64, 1'b0);
    checks++; if (pulse_cyc.size() - base !== 3) begin errors++; $display("FAIL cont_pulse_count: got %0d want 3", pulse_cyc.size() - base); end
    if (pulse_cyc.size() - base >= 3) begin
      checks++; if (pulse_cyc[base] !== c0 + 22) begin errors++; $display("FAIL cont_first_pulse: got cycle %0d want %0d", pulse_cyc[base] - c0, 22); end
      checks++; if (pulse_cyc[base+2] - pulse_cyc[base+1] !== 16) begin errors++; $display("FAIL cont_spacing: got %0d want 16", pulse_cyc[base+2] - pulse_cyc[base+1]); end
    end
    checks++; if (period !== 16'd16) begin errors++; $display("FAIL cont_period: got %0d want 16", period); end
    checks++; if (peak_max !== 8'hFF) begin errors++; $display("FAIL cont_peak_max: got %h want ff", peak_max); end
    checks++; if (peak_min !== 8'h01) begin errors++; $display("FAIL cont_peak_min: got %h want 01", peak_min); end
    checks++; if ({locked, timeout} !== 2'b10) begin errors++; $display("FAIL cont_flags: got locked=%0b timeout=%0b want 1/0", locked, timeout); end
  endtask

  // Continues from the continuous-sine state: armed by the trailing 0x0B, window open since sample 54.
  task automatic test_noise();
    int base;
    base = pulse_cyc.size();
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 8'd126 : 8'd131);
    checks++; if (pulse_cyc.size() !== base) begin errors++; $display("FAIL noise_no_pulse: got %0d want 0", pulse_cyc.size() - base); end
    step(8'd200);
    checks++; if (pulse_cyc.size() - base !== 1) begin errors++; $display("FAIL noise_armed_kept: got %0d pulses want 1", pulse_cyc.size() - base); end
    checks++; if (period !== 16'd31) begin errors++; $display("FAIL noise_period: got %0d want 31", period); end
    checks++; if ({peak_max, peak_min} !== 16'hFF0B) begin errors++; $display("FAIL noise_peaks: got %h/%h want ff/0b", peak_max, peak_min); end
    for (int i = 0; i < 4; i++) step((i % 2 == 0) ? 8'd120 : 8'd136);
    checks++; if (pulse_cyc.size() - base !== 3) begin errors++; $display("FAIL min_period_pulses: got %0d want 3", pulse_cyc.size() - base); end
    checks++; if (period !== 16'd2) begin errors++; $display("FAIL min_period: got %0d want 2", period); end
    checks++; if ({peak_max, peak_min} !== 16'h8878) begin errors++; $display("FAIL min_period_peaks: got %h/%h want 88/78", peak_max, peak_min); end
  endtask

  task automatic test_gapped();
    int base, c0;
    do_reset(1'b1, 1'b0);
    base = pulse_cyc.size();
    c0 = cyc;
    run_samples(64, 1'b1);
    checks++; if (pulse_cyc.size() - base !== 3) begin errors++; $display("FAIL gap_pulse_count: got %0d want 3", pulse_cyc.size() - base); end
    if (pulse_cyc.size() - base >= 3) begin
      checks++; if (pulse_cyc[base] !== c0 + 43) begin errors++; $display("FAIL gap_first_pulse: got cycle %0d want 43", pulse_cyc[base] - c0); end
      checks++; if (pulse_cyc[base+1] - pulse_cyc[base] !== 32) begin errors++; $display("FAIL gap_spacing: got %0d want 32", pulse_cyc[base+1] - pulse_cyc[base]); end
    end
    checks++; if (period !== 16'd16) begin errors++; $display("FAIL gap_period: got %0d want 16", period); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset(1'b1, 1'b0);
    run_samples(30, 1'b0);
    checks++; if (period !== 16'd16) begin errors++; $display("FAIL mid_pre_period: got %0d want 16", period); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({period, peak_max, peak_min} !== 32'd0) begin errors++; $display("FAIL mid_async_clear: got %0d/%h/%h want 0/00/00", period, peak_max, peak_min); end
    checks++; if ({meas_valid, locked, timeout} !== 3'b000) begin errors++; $display("FAIL mid_async_flags: got %b want 000", {meas_valid, locked, timeout}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = pulse_cyc.size();
    run_samples(21, 1'b0);
    checks++; if (pulse_cyc.size() !== base) begin errors++; $display("FAIL mid_one_crossing: got %0d pulses want 0", pulse_cyc.size() - base); end
    step(sine_tab[21 % 16]);
    checks++; if (pulse_cyc.size() - base !== 1) begin errors++; $display("FAIL mid_two_crossings: got %0d pulses want 1", pulse_cyc.size() - base); end
    checks++; if (period !== 16'd16) begin errors++; $display("FAIL mid_relock_period: got %0d want 16", period); end
  endtask

  task automatic test_timeout();
    int base;
    do_reset(1'b0, 1'b1);
    base = pulses2;
    step(8'd30); step(8'd200); step(8'd30); step(8'd200);
    checks++; if (pulses2 - base !== 1 || period2 !== 4'd2) begin errors++; $display("FAIL to_prelock: got pulses=%0d period=%0d want 1/2", pulses2 - base, period2); end
    for (int i = 0; i < 15; i++) step(8'd200);
    checks++; if (timeout2 !== 1'b0) begin errors++; $display("FAIL to_not_yet: got %0b want 0", timeout2); end
    step(8'd200);
    checks++; if ({timeout2, locked2} !== 2'b10) begin errors++; $display("FAIL to_set: got timeout=%0b locked=%0b want 1/0", timeout2, locked2); end
    checks++; if (period2 !== 4'd2) begin errors++; $display("FAIL to_period_held: got %0d want 2", period2); end
    step(8'd30); step(8'd90); step(8'd200); step(8'd160);
    step(8'd30); step(8'd90); step(8'd200);
    checks++; if (pulses2 - base !== 2 || period2 !== 4'd4) begin errors++; $display("FAIL to_relock: got pulses=%0d period=%0d want 2/4", pulses2 - base, period2); end
    checks++; if ({peak_max2, peak_min2} !== {8'd200, 8'd30}) begin errors++; $display("FAIL to_relock_peaks: got %0d/%0d want 200/30", peak_max2, peak_min2); end
    checks++; if ({locked2, timeout2} !== 2'b11) begin errors++; $display("FAIL to_sticky: got locked=%0b timeout=%0b want 1/1", locked2, timeout2); end
    ena2 = 1'b0;
    gap();
    checks++; if ({locked2, timeout2} !== 2'b01) begin errors++; $display("FAIL to_ena_low: got locked=%0b timeout=%0b want 0/1", locked2, timeout2); end
    ena2 = 1'b1;
    gap();
    checks++; if (timeout2 !== 1'b0 || period2 !== 4'd4) begin errors++; $display("FAIL to_ena_rise: got timeout=%0b period=%0d want 0/4", timeout2, period2); end
    base = pulses2;
    step(8'd30); step(8'd200); step(8'd30);
    ena2 = 1'b0;
    step(8'd200);
    gap();
    checks++; if (pulses2 !== base) begin errors++; $display("FAIL ena_beats_crossing: got %0d pulses want 0", pulses2 - base); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_sine_continuous();
    test_noise();
    test_gapped();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sine_period_meter.md
# sine_period_meter

Receive-side companion to the pure sine generator. Consumes the 8-bit sample stream the generator drives on its output pins and measures it per cycle of the waveform: period in samples, peak maximum and peak minimum. Used in loopback (generator output fed back via `uio_in`) for on-chip self-test, and as a standalone tone analyser.

## Interface
- `SAMPLE_W`, 8: sample width, unsigned, midscale-offset.
- `PERIOD_W`, 16: period counter width.
- `MID`, 128: midscale crossing threshold.
- `HYST`, 4: hysteresis half-width around `MID`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  block enable; low holds the block idle.
- `sample_valid`  in  1  qualifies `sample` this cycle.
- `sample`  in  SAMPLE_W  input sample.
- `meas_valid`  out  1  one-cycle pulse; a new measurement is on the outputs.
- `period`  out  PERIOD_W  last measured period, in valid samples.
- `peak_max`  out  SAMPLE_W  largest sample in the last period.
- `peak_min`  out  SAMPLE_W  smallest sample in the last period.
- `locked`  out  1  at least one measurement taken since the last loss of lock.
- `timeout`  out  1  sticky; period counter saturated.

## Operation
- Only cycles with `ena=1` and `sample_valid=1` ("accepted samples") advance any state.
- Crossing detector:
  - `armed` sets on an accepted sample `<= MID-HYST`.
  - A rising crossing is an accepted sample `>= MID+HYST` while `armed`. It clears `armed` in the same cycle.
  - Samples strictly inside the hysteresis band change nothing.
- FSM states `WAIT_FIRST`, `MEASURE`.
  - `WAIT_FIRST`: no counting. On a crossing: `cnt<=0`, `run_max<=sample`, `run_min<=sample`, go to `MEASURE`.
  - `MEASURE`, non-crossing accepted sample: `cnt<=cnt+1`; update `run_max` and `run_min`.
  - `MEASURE`, crossing: latch `period<=cnt+1`, `peak_max<=run_max`, `peak_min<=run_min`. Pulse `meas_valid`, set `locked`. Reseed `cnt`, `run_max` and `run_min` from this sample, as in `WAIT_FIRST`. Stay in `MEASURE`.
  - Window definition: the crossing sample opens the window and is included; the next crossing sample closes it, is excluded, and seeds the next window.
  - `MEASURE` with `cnt` at all-ones and a further non-crossing accepted sample: set `timeout`, clear `locked`, go to `WAIT_FIRST`. The last measurement outputs are retained.
- `ena` low: FSM to `WAIT_FIRST`, `armed` cleared, `locked` cleared. `period`, `peak_*` and `timeout` are held.
- `timeout` clears only on reset, or on `ena` rising.
- All comparisons are unsigned at `SAMPLE_W` bits. `MID±HYST` is computed at elaboration; the parameters must satisfy `HYST<=MID` and `MID+HYST<2^SAMPLE_W`.

## Timing
- Reset values: all outputs 0; FSM `WAIT_FIRST`; `armed=0`; `cnt=0`; `run_max=0`; `run_min=all-ones`.
- Latency: `meas_valid` and the new `period`/`peak_*` appear on the clock edge after the cycle carrying the closing crossing sample. That is, they are registered with 1-cycle latency.
- `meas_valid` is high for exactly one cycle. The outputs are stable until the next pulse.
- Gaps in `sample_valid` are transparent: the period counts samples, not clocks.
- Back-to-back crossings are impossible: a crossing requires a re-arm on an earlier sample. The minimum reported period is therefore 2.
- Reset asserted mid-window: immediate, asynchronous clear to the reset values. No `meas_valid` is produced.
- `ena` falling in the same cycle as a crossing: `ena` wins, and no measurement is taken.

## Structure
- `sine_meas_pkg`: FSM state enum (`WAIT_FIRST`, `MEASURE`), default `MID`/`HYST` constants, and a shared `SAMPLE_W` default.
- Sub-module `sine_xing_det`:
  - Inputs: `clk`, `rst_n`, `ena`, the accepted-sample strobe, `sample`.
  - Outputs: a single-cycle combinational `xing` flag; owns `armed`.
- The top holds the FSM, counter and min/max trackers, and the output registers.

## Test plan
- Reset and idle: after reset all outputs are 0. Constant `sample=128` for 100 accepted samples gives no `meas_valid` and no `timeout`.
- 16-entry sine table (min 0x01, max 0xFF), repeated 4×, `sample_valid` continuous:
  - First `meas_valid` comes one cycle after the 17th crossing-sample cycle.
  - `period=16`, `peak_max=0xFF`, `peak_min=0x01`, `locked=1`.
  - 3 pulses total.
- Same table with `sample_valid` toggling every other cycle: `period=16`, and pulses are spaced 32 clocks apart.
- Noise: alternate 126/131 (inside band, `HYST=4`) after a valid lock gives no new `meas_valid` and no `armed` change. Alternate 120/136 gives `period=2`.
- Timeout with `PERIOD_W=4`: one crossing, then 16 samples of 200 gives `timeout=1` and `locked=0`. The previous `period` is held. A subsequent clean sine relocks, and `timeout` stays 1 until `ena` toggles.
- Reset mid-window (8 samples into a period): outputs are 0 on the same edge. The first pulse after reset needs two fresh crossings.
